// File: rtl/pid_pkg.sv
// Shared definitions for the multi-channel PID core: FSM state encoding,
// coefficient-select codes and the common saturation helper.
package pid_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ERR   = 3'd1,
        ST_INT   = 3'd2,
        ST_MUL_P = 3'd3,
        ST_MUL_I = 3'd4,
        ST_MUL_D = 3'd5,
        ST_OUT   = 3'd6
    } state_t;

    localparam logic [1:0] SEL_KP = 2'd0;
    localparam logic [1:0] SEL_KI = 2'd1;
    localparam logic [1:0] SEL_KD = 2'd2;

    // Common working width for saturation. Callers sign-extend their
    // operands to this width and truncate the result back to their own
    // width, so one function serves every datapath width up to SAT_W.
    localparam int SAT_W = 128;
    typedef logic signed [SAT_W-1:0] sat_t;

    // Clamp x into [lo, hi]; an inverted window (lo > hi) always yields lo.
    function automatic sat_t sat(input sat_t x, input sat_t lo, input sat_t hi);
        sat_t r;
        if (lo > hi)
            r = lo;
        else if (x > hi)
            r = hi;
        else if (x < lo)
            r = lo;
        else
            r = x;
        return r;
    endfunction

endpackage

// File: rtl/pid_coef_bank.sv
// Double-banked per-channel kp/ki/kd storage. The shadow bank takes writes
// at any time; the active bank is refreshed from the shadow only on i_copy
// (run start), so coefficients never change in the middle of a run.
module pid_coef_bank
    import pid_pkg::*;
#(
    parameter  int NUM_CH     = 4,
    parameter  int VAL_LENGTH = 32,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_we,
    input  logic [CH_W-1:0]       i_ch,
    input  logic [1:0]            i_sel,
    input  logic [VAL_LENGTH-1:0] i_data,
    input  logic                  i_copy,
    input  logic [CH_W-1:0]       i_rd_ch,
    output logic [VAL_LENGTH-1:0] o_kp,
    output logic [VAL_LENGTH-1:0] o_ki,
    output logic [VAL_LENGTH-1:0] o_kd
);

    logic [VAL_LENGTH-1:0] w_act_kp [NUM_CH];
    logic [VAL_LENGTH-1:0] w_act_ki [NUM_CH];
    logic [VAL_LENGTH-1:0] w_act_kd [NUM_CH];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [VAL_LENGTH-1:0] r_sh_kp, r_sh_ki, r_sh_kd;
            logic [VAL_LENGTH-1:0] r_act_kp, r_act_ki, r_act_kd;
            logic                  w_hit;

            // Writes to channel indices beyond NUM_CH match no slot and vanish.
            assign w_hit = i_we && (i_ch == CH_W'(gi));

            // Shadow bank write decode; select code 3 is a no-op.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_sh_kp <= '0;
                    r_sh_ki <= '0;
                    r_sh_kd <= '0;
                end else if (w_hit) begin
                    case (i_sel)
                        SEL_KP:  r_sh_kp <= i_data;
                        SEL_KI:  r_sh_ki <= i_data;
                        SEL_KD:  r_sh_kd <= i_data;
                        default: ;
                    endcase
                end
            end

            // Active bank snapshot taken on the run-start edge.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_act_kp <= '0;
                    r_act_ki <= '0;
                    r_act_kd <= '0;
                end else if (i_copy) begin
                    r_act_kp <= r_sh_kp;
                    r_act_ki <= r_sh_ki;
                    r_act_kd <= r_sh_kd;
                end
            end

            assign w_act_kp[gi] = r_act_kp;
            assign w_act_ki[gi] = r_act_ki;
            assign w_act_kd[gi] = r_act_kd;
        end
    endgenerate

    assign o_kp = w_act_kp[i_rd_ch];
    assign o_ki = w_act_ki[i_rd_ch];
    assign o_kd = w_act_kd[i_rd_ch];

endmodule

// File: rtl/pid_mc_core.sv
// Time-multiplexed multi-channel positional PID. One signed multiplier is
// stepped through every channel by a six-state-per-channel FSM.
// Optional feature macro: PID_ANTIWINDUP_FREEZE_EN - when defined, output
// saturation flags freeze the integrator while the error would push it
// further into the saturated direction.
module pid_mc_core
    import pid_pkg::*;
#(
    parameter  int NUM_CH     = 4,
    parameter  int VAL_LENGTH = 32,
    parameter  int FRAC_BITS  = 16,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         sys_clk,
    input  logic                         sys_rst_n,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    input  logic                         clr,
    input  logic [NUM_CH*VAL_LENGTH-1:0] target,
    input  logic [NUM_CH*VAL_LENGTH-1:0] current_value,
    input  logic [VAL_LENGTH-1:0]        int_max,
    input  logic [VAL_LENGTH-1:0]        int_min,
    input  logic [VAL_LENGTH-1:0]        dif_max,
    input  logic [VAL_LENGTH-1:0]        dif_min,
    input  logic [VAL_LENGTH-1:0]        uk_max,
    input  logic [VAL_LENGTH-1:0]        uk_min,
    input  logic                         cfg_we,
    input  logic [CH_W-1:0]              cfg_ch,
    input  logic [1:0]                   cfg_sel,
    input  logic [VAL_LENGTH-1:0]        cfg_data,
    output logic [NUM_CH*VAL_LENGTH-1:0] pid_out
);

    localparam int VL     = VAL_LENGTH;
    localparam int PROD_W = 2 * VL;
    localparam int ACC_W  = 2 * VL + 2;

    // Representable range of a VL-bit signed error, for clamping the
    // VL+1-bit difference.
    localparam sat_t E_MAX = sat_t'({(VL-1){1'b1}});
    localparam sat_t E_MIN = ~E_MAX;

    state_t                 r_state, w_state_next;
    logic                   w_accept, w_done_next, w_last, w_clr_now;
    logic [CH_W-1:0]        r_ch;
    logic signed [VL-1:0]   r_e, r_d;
    logic signed [ACC_W-1:0] r_acc;
    logic                   r_done, r_clr_pend;

    logic signed [VL-1:0]   w_tgt   [NUM_CH];
    logic signed [VL-1:0]   w_cur   [NUM_CH];
    logic signed [VL-1:0]   w_integ [NUM_CH];
    logic signed [VL-1:0]   w_eprev [NUM_CH];

    logic [VL-1:0]          w_kp, w_ki, w_kd;
    logic signed [VL-1:0]   w_mul_a, w_mul_b;
    logic signed [PROD_W-1:0] w_prod;

    logic signed [VL:0]     w_diff;
    logic signed [VL-1:0]   w_e_new, w_integ_new, w_d_new, w_out_new;
    logic signed [VL-1:0]   w_integ_c, w_eprev_c;
    logic signed [ACC_W-1:0] w_shift;
    sat_t                   w_shift_x, w_umin, w_umax;
    logic                   w_hold;

    assign w_accept  = (r_state == ST_IDLE) && start;
    assign w_last    = (r_ch == CH_W'(NUM_CH - 1));
    assign w_clr_now = (r_state == ST_IDLE) && (clr || r_clr_pend);
    assign busy      = (r_state != ST_IDLE);
    assign done      = r_done;

    pid_coef_bank #(
        .NUM_CH     (NUM_CH),
        .VAL_LENGTH (VAL_LENGTH)
    ) u_coef (
        .i_clk   (sys_clk),
        .i_rst_n (sys_rst_n),
        .i_we    (cfg_we),
        .i_ch    (cfg_ch),
        .i_sel   (cfg_sel),
        .i_data  (cfg_data),
        .i_copy  (w_accept),
        .i_rd_ch (r_ch),
        .o_kp    (w_kp),
        .o_ki    (w_ki),
        .o_kd    (w_kd)
    );

    // Current-channel operands and stage results.
    assign w_integ_c = w_integ[r_ch];
    assign w_eprev_c = w_eprev[r_ch];
    assign w_diff    = $signed({w_tgt[r_ch][VL-1], w_tgt[r_ch]})
                     - $signed({w_cur[r_ch][VL-1], w_cur[r_ch]});
    assign w_e_new     = VL'(sat(sat_t'(w_diff), E_MIN, E_MAX));
    assign w_integ_new = VL'(sat(sat_t'(w_integ_c) + sat_t'(r_e),
                                 sat_t'($signed(int_min)), sat_t'($signed(int_max))));
    assign w_d_new     = VL'(sat(sat_t'(r_e) - sat_t'(w_eprev_c),
                                 sat_t'($signed(dif_min)), sat_t'($signed(dif_max))));
    assign w_shift   = r_acc >>> FRAC_BITS;
    assign w_shift_x = sat_t'(w_shift);
    assign w_umin    = sat_t'($signed(uk_min));
    assign w_umax    = sat_t'($signed(uk_max));
    assign w_out_new = VL'(sat(w_shift_x, w_umin, w_umax));

    // Shared multiplier operand selection by MUL stage.
    always_comb begin
        w_mul_a = w_kp;
        w_mul_b = r_e;
        case (r_state)
            ST_MUL_I: begin
                w_mul_a = w_ki;
                w_mul_b = w_integ_c;
            end
            ST_MUL_D: begin
                w_mul_a = w_kd;
                w_mul_b = r_d;
            end
            default: ;
        endcase
    end

    assign w_prod = PROD_W'(w_mul_a) * PROD_W'(w_mul_b);

`ifdef PID_ANTIWINDUP_FREEZE_EN
    logic [NUM_CH-1:0] w_sat_hi, w_sat_lo;
    logic              w_flag_hi, w_flag_lo;
    // An inverted output window always clamps to uk_min, so it counts as low.
    assign w_flag_lo = (w_umin > w_umax) || (w_shift_x < w_umin);
    assign w_flag_hi = !w_flag_lo && (w_shift_x > w_umax);
    assign w_hold    = (w_sat_hi[r_ch] && (r_e > 0)) || (w_sat_lo[r_ch] && (r_e < 0));
`else
    assign w_hold    = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    // FSM next-state and end-of-run pulse decode.
    always_comb begin
        w_state_next = r_state;
        w_done_next  = 1'b0;
        case (r_state)
            ST_IDLE:  if (start) w_state_next = ST_ERR;
            ST_ERR:   w_state_next = ST_INT;
            ST_INT:   w_state_next = ST_MUL_P;
            ST_MUL_P: w_state_next = ST_MUL_I;
            ST_MUL_I: w_state_next = ST_MUL_D;
            ST_MUL_D: w_state_next = ST_OUT;
            ST_OUT: begin
                if (w_last) begin
                    w_state_next = ST_IDLE;
                    w_done_next  = 1'b1;
                end else begin
                    w_state_next = ST_ERR;
                end
            end
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Channel sequencing, per-channel scratch, accumulator and deferred clear.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_ch       <= '0;
            r_e        <= '0;
            r_d        <= '0;
            r_acc      <= '0;
            r_done     <= 1'b0;
            r_clr_pend <= 1'b0;
        end else begin
            r_done <= w_done_next;
            if (w_clr_now)
                r_clr_pend <= 1'b0;
            else if (clr && (r_state != ST_IDLE))
                r_clr_pend <= 1'b1;
            case (r_state)
                ST_ERR:   r_e   <= w_e_new;
                ST_INT:   r_d   <= w_d_new;
                ST_MUL_P: r_acc <= ACC_W'(w_prod);
                ST_MUL_I: r_acc <= r_acc + ACC_W'(w_prod);
                ST_MUL_D: r_acc <= r_acc + ACC_W'(w_prod);
                ST_OUT:   r_ch  <= w_last ? '0 : r_ch + 1'b1;
                default:  ;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic signed [VL-1:0] r_integ, r_eprev, r_out;
            logic                 w_sel;
`ifdef PID_ANTIWINDUP_FREEZE_EN
            logic                 r_sat_hi, r_sat_lo;
            assign w_sat_hi[gi] = r_sat_hi;
            assign w_sat_lo[gi] = r_sat_lo;
`endif
            assign w_sel = (r_ch == CH_W'(gi));

            // Per-channel integrator, previous error and output word.
            always_ff @(posedge sys_clk or negedge sys_rst_n) begin
                if (!sys_rst_n) begin
                    r_integ <= '0;
                    r_eprev <= '0;
                    r_out   <= '0;
`ifdef PID_ANTIWINDUP_FREEZE_EN
                    r_sat_hi <= 1'b0;
                    r_sat_lo <= 1'b0;
`endif
                end else if (w_clr_now) begin
                    r_integ <= '0;
                    r_eprev <= '0;
`ifdef PID_ANTIWINDUP_FREEZE_EN
                    r_sat_hi <= 1'b0;
                    r_sat_lo <= 1'b0;
`endif
                end else if (w_sel) begin
                    if ((r_state == ST_INT) && !w_hold)
                        r_integ <= w_integ_new;
                    if (r_state == ST_OUT) begin
                        r_eprev <= r_e;
                        r_out   <= w_out_new;
`ifdef PID_ANTIWINDUP_FREEZE_EN
                        r_sat_hi <= w_flag_hi;
                        r_sat_lo <= w_flag_lo;
`endif
                    end
                end
            end

            assign w_tgt[gi]   = $signed(target[gi*VL +: VL]);
            assign w_cur[gi]   = $signed(current_value[gi*VL +: VL]);
            assign w_integ[gi] = r_integ;
            assign w_eprev[gi] = r_eprev;
            assign pid_out[gi*VL +: VL] = r_out;
        end
    endgenerate

endmodule

// File: tb/tb_pid_mc_core.sv
// Scoreboard bench for pid_mc_core (NUM_CH=4, VAL_LENGTH=32, FRAC_BITS=16).
// Directed runs push their hand-computed outputs and done cycle into a
// queue; an independent monitor pops and compares on every done pulse.
module tb_pid_mc_core;

    localparam int NCH = 4;
    localparam int VL  = 32;

    logic                sys_clk   = 1'b0;
    logic                sys_rst_n = 1'b1;
    logic                start     = 1'b0;
    logic                clr       = 1'b0;
    logic                busy, done;
    logic [NCH*VL-1:0]   target        = '0;
    logic [NCH*VL-1:0]   current_value = '0;
    logic [VL-1:0]       int_max = 32'h7FFF_FFFF, int_min = 32'h8000_0000;
    logic [VL-1:0]       dif_max = 32'h7FFF_FFFF, dif_min = 32'h8000_0000;
    logic [VL-1:0]       uk_max  = 32'h7FFF_FFFF, uk_min  = 32'h8000_0000;
    logic                cfg_we  = 1'b0;
    logic [1:0]          cfg_ch  = '0;
    logic [1:0]          cfg_sel = '0;
    logic [VL-1:0]       cfg_data = '0;
    logic [NCH*VL-1:0]   pid_out;

    pid_mc_core #(.NUM_CH(NCH), .VAL_LENGTH(VL), .FRAC_BITS(16)) dut (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .clr           (clr),
        .target        (target),
        .current_value (current_value),
        .int_max       (int_max),
        .int_min       (int_min),
        .dif_max       (dif_max),
        .dif_min       (dif_min),
        .uk_max        (uk_max),
        .uk_min        (uk_min),
        .cfg_we        (cfg_we),
        .cfg_ch        (cfg_ch),
        .cfg_sel       (cfg_sel),
        .cfg_data      (cfg_data),
        .pid_out       (pid_out)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    typedef struct {
        int                done_cyc;
        logic [NCH*VL-1:0] out;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   n_done = 0;
    int   n_exp  = 0;

    function automatic logic [NCH*VL-1:0] pack4(input logic [VL-1:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    // Monitor: every done pulse is matched against the oldest expectation.
    always @(negedge sys_clk) begin
        exp_t e;
        if (done === 1'b1) begin
            n_done++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done cycle=%0d", cyc);
            end else begin
                e = sb.pop_front();
                checks++;
                if (cyc != e.done_cyc) begin
                    errors++;
                    $display("FAIL done_cycle got=%0d exp=%0d", cyc, e.done_cyc);
                end
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_at_done got=%b exp=0", busy);
                end
                for (int i = 0; i < NCH; i++) begin
                    checks++;
                    if (pid_out[i*VL +: VL] !== e.out[i*VL +: VL]) begin
                        errors++;
                        $display("FAIL pid_out_ch%0d cycle=%0d got=%0d exp=%0d", i, cyc,
                                 $signed(pid_out[i*VL +: VL]), $signed(e.out[i*VL +: VL]));
                    end
                end
                $display("run done cycle=%0d out=%0d,%0d,%0d,%0d", cyc,
                         $signed(pid_out[0 +: VL]), $signed(pid_out[VL +: VL]),
                         $signed(pid_out[2*VL +: VL]), $signed(pid_out[3*VL +: VL]));
            end
        end
    end

    task automatic cfg(input int ch, input int sel, input logic [VL-1:0] d);
        @(negedge sys_clk);
        cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_sel = 2'(sel); cfg_data = d;
        @(negedge sys_clk);
        cfg_we = 1'b0;
    endtask

    task automatic set_io(input logic [VL-1:0] t0, t1, t2, t3, c0, c1, c2, c3);
        @(negedge sys_clk);
        target        = pack4(t0, t1, t2, t3);
        current_value = pack4(c0, c1, c2, c3);
    endtask

    // Pulse start (optionally with clr); done is due 25 cycles after accept.
    task automatic kick(input logic push, input logic with_clr, input logic [NCH*VL-1:0] e);
        exp_t x;
        @(negedge sys_clk);
        start = 1'b1;
        clr   = with_clr;
        if (push) begin
            x.done_cyc = cyc + 25;
            x.out      = e;
            sb.push_back(x);
            n_exp++;
        end
        @(negedge sys_clk);
        start = 1'b0;
        clr   = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_start got=%b exp=1", busy);
        end
    endtask

    task automatic wait_done();
        int i;
        i = 0;
        while (sb.size() != 0 && i < 60) begin
            @(negedge sys_clk);
            i++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL done_timeout pending=%0d exp=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic run(input logic [NCH*VL-1:0] e);
        kick(1'b1, 1'b0, e);
        wait_done();
    endtask

    initial begin
        #1 sys_rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++;
        if (pid_out !== '0) begin errors++; $display("FAIL reset_pid_out got=%h exp=0", pid_out); end
        sys_rst_n = 1'b1;

        cfg(0, 0, 32'h0001_0000);
        cfg(1, 1, 32'h0000_8000);
        cfg(2, 2, 32'h0001_0000);
        cfg(0, 3, 32'h0007_0000);

        set_io(100, 10, 0, 5, 40, 0, 0, 0);
        run(pack4(60, 5, 0, 0));
        set_io(100, 10, 50, 5, 40, 0, 0, 0);
        run(pack4(60, 10, 50, 0));

        // Integrator and derivative limits; error clamp at full range.
        int_max = 20;
        dif_max = 30;
        cfg(3, 0, 32'h0001_0000);
        set_io(0, 10, 100, 32'h7FFF_FFFF, 40, 0, 0, 32'h8000_0000);
        run(pack4(-40, 10, 30, 32'h7FFF_FFFF));

        // Coefficient write and stray starts while busy.
        int_max = 32'h7FFF_FFFF;
        dif_max = 32'h7FFF_FFFF;
        set_io(100, 10, 100, 7, 40, 0, 0, 0);
        kick(1'b1, 1'b0, pack4(60, 15, 0, 7));
        for (int k = 2; k <= 24; k++) begin
            @(negedge sys_clk);
            start    = (k == 3 || k == 10 || k == 20);
            cfg_we   = (k == 5);
            cfg_ch   = 2'd0;
            cfg_sel  = 2'd0;
            cfg_data = 32'h0002_0000;
        end
        @(negedge sys_clk);
        start  = 1'b0;
        cfg_we = 1'b0;
        wait_done();
        repeat (30) @(negedge sys_clk);
        checks++;
        if (n_done != n_exp) begin
            errors++;
            $display("FAIL extra_done got=%0d exp=%0d", n_done, n_exp);
        end

        // clr during a run takes effect only after it completes.
        kick(1'b1, 1'b0, pack4(120, 20, 0, 7));
        repeat (4) @(negedge sys_clk);
        clr = 1'b1;
        @(negedge sys_clk);
        clr = 1'b0;
        wait_done();
        run(pack4(120, 5, 100, 7));

        // Output saturation, clr together with start.
        cfg(0, 0, 32'h0010_0000);
        cfg(0, 1, 32'h0001_0000);
        uk_max = 1000;
        set_io(100, 10, 100, 7, 0, 0, 0, 0);
        kick(1'b1, 1'b1, pack4(1000, 5, 100, 7));
        wait_done();
        run(pack4(1000, 10, 0, 7));
        cfg(0, 0, 32'h0000_0000);
        uk_max = 32'h7FFF_FFFF;
`ifdef PID_ANTIWINDUP_FREEZE_EN
        run(pack4(100, 15, 0, 7));
`else
        run(pack4(300, 15, 0, 7));
`endif

        // Reset at cycle 7 of a run: everything clears, no done.
        kick(1'b0, 1'b0, '0);
        repeat (6) @(negedge sys_clk);
        sys_rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        checks++;
        if (pid_out !== '0) begin errors++; $display("FAIL midrst_pid_out got=%h exp=0", pid_out); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL midrst_done got=%b exp=0", done); end
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (40) @(negedge sys_clk);
        checks++;
        if (n_done != n_exp) begin
            errors++;
            $display("FAIL midrst_no_done got=%0d exp=%0d", n_done, n_exp);
        end

        cfg(1, 1, 32'h0000_8000);
        run(pack4(0, 5, 0, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
